branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
Set-associative branch target buffer and the consumer of the BTUpdate stream that the integer ALUs produce on resolved taken branches and mispredicted indirect jumps. The fetch stage looks up the fetch PC and gets a registered target, jump, call and compressed attributes one cycle later. Entries are allocated or overwritten by updates, and removed individually by clean updates. After reset, a clear state machine walks the table before the buffer reports ready.

Parameters:
NUM_SETS, 64, number of sets; power of two; index = pc[IDX_BITS:1], IDX_BITS = log2(NUM_SETS)
NUM_WAYS, 2, associativity; power of two, at least 1
TAG_BITS, 8, stored partial tag = pc[IDX_BITS+TAG_BITS:IDX_BITS+1]

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
IN_lookupValid  in  1  fetch lookup request
IN_lookupPC  in  32  fetch halfword address; bit 0 ignored
OUT_ready  out  1  table cleared, lookups and updates are live
OUT_hit  out  1  registered lookup hit
OUT_src  out  32  stored source PC (index and tag bits, other bits 0)
OUT_dst  out  32  predicted target; bit 0 always 0
OUT_isJump  out  1  entry is an unconditional or indirect jump
OUT_isCall  out  1  entry is a call
OUT_compressed  out  1  branch is a 16-bit instruction
IN_btUpdate  in  BTUpdate  valid, src, dst, isJump, isCall, compressed, clean

Behaviour:
- Reset (rst=0), held any length: FSM enters CLEAR, clear pointer = 0, all outputs 0.
- CLEAR state:
  - Each cycle with rst=1 clears the valid bits and the replacement pointer of the set at the clear pointer, then increments the pointer.
  - After set NUM_SETS-1 is cleared, the FSM moves to READY.
  - OUT_ready rises exactly NUM_SETS cycles after rst is released.
  - In CLEAR, lookups return OUT_hit=0 and updates are dropped.
- Reset during READY: restarts CLEAR on the next edge. The table has no content guarantee until OUT_ready=1.
- Lookup timing: 1-cycle latency. A request at edge N with IN_lookupValid=1 produces OUT_hit and attributes valid after edge N+1.
  - IN_lookupValid=0, or a miss: OUT_hit=0. The attribute outputs hold their previous value.
- Hit rule: the entry is valid and the stored tag equals the lookup tag. If several ways match, the lowest way wins.
- Update with valid=1 and clean=0:
  - If the src tag matches a valid way in its set, that way is overwritten in place and the replacement pointer is unchanged.
  - Otherwise the way selected by the set's replacement pointer is written. The pointer then increments modulo NUM_WAYS (round-robin, starting at way 0).
- Update with valid=1 and clean=1: invalidates the matching way if one exists, otherwise has no effect. The pointer is unchanged.
- Lookup and update in the same cycle to the same set: the lookup returns the pre-update contents (read-before-write). The new entry is visible to a lookup issued on the next cycle.
- The update path is never back-pressured. At most one update per cycle.
- Stored dst bit 0 is forced to 0. The src/dst width is 32 with no wrap handling; targets are taken as given.

Decomposition:
- The shared package holds:
  - the BTUpdate struct (already shared with the ALUs)
  - a new BTBEntry struct {valid, tag, dst[31:1], isJump, isCall, compressed}
  - the BTB_SETS, BTB_WAYS and BTB_TAG_BITS defaults
- One sub-module, btb_way_ram: a single-port-write, single-port-read array of BTBEntry with synchronous read. It is instantiated per way.
- The FSM, tag compare, replacement pointers and clear logic stay in the top level.

Test Plan:
- Reset clear: release rst, then issue a lookup on every cycle. Required: OUT_ready=0 and OUT_hit=0 for cycles 0-63; OUT_ready=1 at cycle 64.
- Basic allocation: update {src=0x1004, dst=0x2000, isJump=0}, then look up 0x1004 on the next cycle. Required: OUT_hit=1 and OUT_dst=0x2000 one cycle later. A lookup of 0x1006 (set 3) must miss.
- Replacement: updates to 0x1004, 0x1084 and 0x1104 (all set 2, tags 0x20, 0x21 and 0x22) with dst values 0xA0, 0xB0 and 0xC0. Required: 0x1004 misses, 0x1084 hits with dst=0xB0, 0x1104 hits with dst=0xC0.
- Overwrite and clean: update 0x1004 to dst=0x3000 with isCall=1, then look up. Required: hit with dst=0x3000 and isCall=1. After a clean update on 0x1004, the lookup must miss.
- Same-cycle collision: lookup of 0x1004 and update of 0x1004 (dst=0x4000) in the same cycle. Required: the result shows the old dst (or a miss if the entry was absent). The next-cycle lookup returns 0x4000.
- Mid-operation reset: with the table populated, pulse rst low for 1 cycle. Required: OUT_ready=0 for 64 cycles, and afterwards every earlier entry misses.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer and the ALU update stream.
// BTBEntry is the per-way storage word; BTUpdate comes from the ALUs.
package branch_target_buffer_pkg;

    localparam int BTB_SETS = 64;
    localparam int BTB_WAYS = 2;
    localparam int BTB_TAG_BITS = 8;

    typedef struct packed {
        logic valid;
        logic [31:0] src;
        logic [31:0] dst;
        logic isJump;
        logic isCall;
        logic compressed;
        logic clean;
    } BTUpdate;

    typedef struct packed {
        logic valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [31:1] dst;
        logic isJump;
        logic isCall;
        logic compressed;
    } BTBEntry;

    typedef enum logic {
        CLEAR,
        READY
    } btbState_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup bus and ALU update stream of the branch target buffer.
// master = fetch/ALU side, slave = the buffer.
interface branch_target_buffer_if;
    import branch_target_buffer_pkg::*;

    logic IN_lookupValid;
    logic [31:0] IN_lookupPC;
    BTUpdate IN_btUpdate;
    logic OUT_ready;
    logic OUT_hit;
    logic [31:0] OUT_src;
    logic [31:0] OUT_dst;
    logic OUT_isJump;
    logic OUT_isCall;
    logic OUT_compressed;

    modport master (
        output IN_lookupValid, IN_lookupPC, IN_btUpdate,
        input OUT_ready, OUT_hit, OUT_src, OUT_dst,
        input OUT_isJump, OUT_isCall, OUT_compressed
    );

    modport slave (
        input IN_lookupValid, IN_lookupPC, IN_btUpdate,
        output OUT_ready, OUT_hit, OUT_src, OUT_dst,
        output OUT_isJump, OUT_isCall, OUT_compressed
    );

endinterface

// File: rtl/branch_target_buffer_way_ram.sv
// One way of the BTB: entry array with one write port and a
// synchronous read port (read-before-write on the same address).
module btb_way_ram
    import branch_target_buffer_pkg::*;
#(
    parameter int DEPTH = BTB_SETS,
    parameter int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] waddr,
    input BTBEntry wdata,
    input logic re,
    input logic [AW-1:0] raddr,
    output BTBEntry rdata
);

    BTBEntry mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Set-associative branch target buffer: registered fetch lookup,
// ALU-driven allocate/overwrite/clean, post-reset table clear.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int NUM_SETS = BTB_SETS,
    parameter int NUM_WAYS = BTB_WAYS,
    parameter int TAG_BITS = BTB_TAG_BITS
) (
    input logic clk,
    input logic rst,
    branch_target_buffer_if.slave bus
);

    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_LO = IDX_BITS + 1;
    localparam int TAG_HI = IDX_BITS + TAG_BITS;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;
    typedef logic [WAY_BITS-1:0] way_t;

    btbState_t state, stateNext;
    idx_t clrPtr;
    logic ready;

    BTUpdate upd;
    idx_t lkIdx, upIdx;
    tag_t lkTag, upTag;

    logic lkValidQ;
    idx_t lkIdxQ;
    tag_t lkTagQ;

    logic [NUM_WAYS-1:0] shValid [NUM_SETS];
    tag_t shTag [NUM_SETS][NUM_WAYS];
    way_t rrPtr [NUM_SETS];

    logic upAny;
    way_t upWay, allocWay;
    logic clrGo, updClean, updWrite, rrBump;
    logic [NUM_WAYS-1:0] we;
    idx_t wAddr;
    BTBEntry wData, newEntry;

    BTBEntry rdData [NUM_WAYS];
    logic rdHit;
    way_t rdWay;

    logic hitQ, jumpQ, callQ, compQ;
    logic [31:0] srcQ, dstQ;

    logic unusedBits;

    assign upd = bus.IN_btUpdate;
    assign ready = (state == READY);

    assign lkIdx = bus.IN_lookupPC[IDX_BITS:1];
    assign lkTag = bus.IN_lookupPC[TAG_HI:TAG_LO];
    assign upIdx = upd.src[IDX_BITS:1];
    assign upTag = upd.src[TAG_HI:TAG_LO];

    assign unusedBits = ^{bus.IN_lookupPC[31:TAG_HI+1],
                          bus.IN_lookupPC[0],
                          upd.src[31:TAG_HI+1],
                          upd.src[0], upd.dst[0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            clrPtr <= '0;
        end else begin
            state <= stateNext;
            if (state == CLEAR)
                clrPtr <= clrPtr + 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        if (state == CLEAR && clrPtr == idx_t'(NUM_SETS - 1))
            stateNext = READY;
    end

    // Shadow valid/tag copy lets the update path match without a RAM read
    always_comb begin
        upAny = 1'b0;
        upWay = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (shValid[upIdx][w] && shTag[upIdx][w] == upTag) begin
                upAny = 1'b1;
                upWay = way_t'(w);
            end
        end
    end

    assign allocWay = upAny ? upWay : rrPtr[upIdx];
    assign clrGo = rst && !ready;
    assign updClean = rst && ready && upd.valid && upd.clean;
    assign updWrite = rst && ready && upd.valid && !upd.clean;

    always_comb begin
        newEntry = '0;
        newEntry.valid = 1'b1;
        newEntry.tag = BTB_TAG_BITS'(upTag);
        newEntry.dst = upd.dst[31:1];
        newEntry.isJump = upd.isJump;
        newEntry.isCall = upd.isCall;
        newEntry.compressed = upd.compressed;
    end

    always_comb begin
        we = '0;
        wAddr = upIdx;
        wData = newEntry;
        rrBump = 1'b0;
        unique case (1'b1)
            clrGo: begin
                we = '1;
                wAddr = clrPtr;
                wData = '0;
            end
            updClean: begin
                we[upWay] = upAny;
                wData = '0;
            end
            updWrite: begin
                we[allocWay] = 1'b1;
                rrBump = !upAny;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (we[w]) begin
                shValid[wAddr][w] <= wData.valid;
                shTag[wAddr][w] <= tag_t'(wData.tag);
            end
        end
        if (clrGo)
            rrPtr[clrPtr] <= '0;
        else if (rrBump)
            rrPtr[upIdx] <= (rrPtr[upIdx] == way_t'(NUM_WAYS - 1))
                ? '0 : rrPtr[upIdx] + 1'b1;
    end

    for (genvar g = 0; g < NUM_WAYS; g++) begin : gWay
        btb_way_ram #(
            .DEPTH(NUM_SETS)
        ) uRam (
            .clk(clk),
            .we(we[g]),
            .waddr(wAddr),
            .wdata(wData),
            .re(bus.IN_lookupValid),
            .raddr(lkIdx),
            .rdata(rdData[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst)
            lkValidQ <= 1'b0;
        else
            lkValidQ <= bus.IN_lookupValid && ready;
        lkIdxQ <= lkIdx;
        lkTagQ <= lkTag;
    end

    always_comb begin
        rdHit = 1'b0;
        rdWay = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (rdData[w].valid &&
                rdData[w].tag == BTB_TAG_BITS'(lkTagQ)) begin
                rdHit = 1'b1;
                rdWay = way_t'(w);
            end
        end
    end

    // Attributes only move on a hit; a miss leaves the last target visible
    always_ff @(posedge clk) begin
        if (!rst) begin
            hitQ <= 1'b0;
            srcQ <= '0;
            dstQ <= '0;
            jumpQ <= 1'b0;
            callQ <= 1'b0;
            compQ <= 1'b0;
        end else begin
            hitQ <= lkValidQ && rdHit;
            if (lkValidQ && rdHit) begin
                srcQ <= 32'({lkTagQ, lkIdxQ, 1'b0});
                dstQ <= {rdData[rdWay].dst, 1'b0};
                jumpQ <= rdData[rdWay].isJump;
                callQ <= rdData[rdWay].isCall;
                compQ <= rdData[rdWay].compressed;
            end
        end
    end

    assign bus.OUT_ready = ready;
    assign bus.OUT_hit = hitQ;
    assign bus.OUT_src = srcQ;
    assign bus.OUT_dst = dstQ;
    assign bus.OUT_isJump = jumpQ;
    assign bus.OUT_isCall = callQ;
    assign bus.OUT_compressed = compQ;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: clear timing, allocation,
// replacement, clean, same-cycle collision and mid-run reset.
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    typedef struct {
        logic uV;
        logic [31:0] uSrc;
        logic [31:0] uDst;
        logic uJ, uC, uCmp, uClean;
        logic lV;
        logic [31:0] lPc;
        logic chk;
        logic eHit;
        logic [31:0] eSrc;
        logic [31:0] eDst;
        logic eJ, eC, eCmp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    vec_t vecs [18];

    branch_target_buffer_if bus ();

    branch_target_buffer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.IN_lookupValid = 1'b0;
        bus.IN_lookupPC = '0;
        bus.IN_btUpdate = '0;
    endtask

    task automatic setUpd(input logic [31:0] src, input logic [31:0] dst,
                          input logic j, input logic c, input logic cmp,
                          input logic clean);
        BTUpdate u;
        u = '0;
        u.valid = 1'b1;
        u.src = src;
        u.dst = dst;
        u.isJump = j;
        u.isCall = c;
        u.compressed = cmp;
        u.clean = clean;
        bus.IN_btUpdate = u;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t upV(input logic [31:0] src,
                                 input logic [31:0] dst, input logic j,
                                 input logic c, input logic cmp,
                                 input logic clean);
        vec_t v;
        v = '{default: '0};
        v.uV = 1'b1;
        v.uSrc = src;
        v.uDst = dst;
        v.uJ = j;
        v.uC = c;
        v.uCmp = cmp;
        v.uClean = clean;
        return v;
    endfunction

    function automatic vec_t lkV(input logic lv, input logic [31:0] pc,
                                 input logic hit, input logic [31:0] src,
                                 input logic [31:0] dst, input logic j,
                                 input logic c, input logic cmp);
        vec_t v;
        v = '{default: '0};
        v.lV = lv;
        v.lPc = pc;
        v.chk = 1'b1;
        v.eHit = hit;
        v.eSrc = src;
        v.eDst = dst;
        v.eJ = j;
        v.eC = c;
        v.eCmp = cmp;
        return v;
    endfunction

    task automatic waitClear(input string tag);
        for (int i = 0; i <= 64; i++) begin
            bus.IN_lookupValid = 1'b1;
            bus.IN_lookupPC = 32'h1004;
            chk($sformatf("%s.ready%0d", tag, i), 32'(bus.OUT_ready),
                32'(i == 64));
            chk($sformatf("%s.hit%0d", tag, i), 32'(bus.OUT_hit), 32'd0);
            if (i < 64)
                cycle();
        end
        idle();
        cycle();
        cycle();
    endtask

    task automatic lookupHit(input string tag, input logic [31:0] pc,
                             input logic expHit,
                             input logic [31:0] expDst);
        bus.IN_lookupValid = 1'b1;
        bus.IN_lookupPC = pc;
        cycle();
        idle();
        cycle();
        chk({tag, ".hit"}, 32'(bus.OUT_hit), 32'(expHit));
        if (expHit)
            chk({tag, ".dst"}, bus.OUT_dst, expDst);
    endtask

    initial begin
        vecs[0] = upV(32'h1004, 32'h2000, 0, 0, 0, 0);
        vecs[1] = lkV(1, 32'h1004, 1, 32'h1004, 32'h2000, 0, 0, 0);
        vecs[2] = lkV(1, 32'h1006, 0, 32'h1004, 32'h2000, 0, 0, 0);
        vecs[3] = upV(32'h1004, 32'h00A0, 0, 0, 0, 0);
        vecs[4] = upV(32'h1084, 32'h00B0, 0, 0, 0, 0);
        vecs[5] = upV(32'h1104, 32'h00C0, 0, 0, 0, 0);
        vecs[6] = lkV(1, 32'h1004, 0, 32'h1004, 32'h2000, 0, 0, 0);
        vecs[7] = lkV(1, 32'h1084, 1, 32'h1084, 32'h00B0, 0, 0, 0);
        vecs[8] = lkV(1, 32'h1104, 1, 32'h1104, 32'h00C0, 0, 0, 0);
        vecs[9] = upV(32'h1004, 32'h3000, 0, 1, 0, 0);
        vecs[10] = lkV(1, 32'h1004, 1, 32'h1004, 32'h3000, 0, 1, 0);
        vecs[11] = upV(32'h1004, 32'h0, 0, 0, 0, 1);
        vecs[12] = lkV(1, 32'h1004, 0, 32'h1004, 32'h3000, 0, 1, 0);
        vecs[13] = upV(32'h2010, 32'h7777, 1, 0, 1, 0);
        vecs[14] = lkV(1, 32'h2011, 1, 32'h2010, 32'h7776, 1, 0, 1);
        vecs[15] = upV(32'h007E, 32'hFFFFFFF0, 0, 0, 0, 0);
        vecs[16] = lkV(1, 32'h007E, 1, 32'h007E, 32'hFFFFFFF0, 0, 0, 0);
        vecs[17] = lkV(0, 32'h007E, 0, 32'h007E, 32'hFFFFFFF0, 0, 0, 0);

        idle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("rst.ready", 32'(bus.OUT_ready), 32'd0);
        chk("rst.hit", 32'(bus.OUT_hit), 32'd0);
        chk("rst.src", bus.OUT_src, 32'd0);
        chk("rst.dst", bus.OUT_dst, 32'd0);
        chk("rst.attr", 32'({bus.OUT_isJump, bus.OUT_isCall,
                             bus.OUT_compressed}), 32'd0);
        rst = 1'b1;
        waitClear("clr");

        for (int n = 0; n < 18; n++) begin
            if (vecs[n].uV)
                setUpd(vecs[n].uSrc, vecs[n].uDst, vecs[n].uJ,
                       vecs[n].uC, vecs[n].uCmp, vecs[n].uClean);
            bus.IN_lookupValid = vecs[n].lV;
            bus.IN_lookupPC = vecs[n].lPc;
            cycle();
            idle();
            cycle();
            if (vecs[n].chk) begin
                chk($sformatf("v%0d.hit", n), 32'(bus.OUT_hit),
                    32'(vecs[n].eHit));
                chk($sformatf("v%0d.src", n), bus.OUT_src, vecs[n].eSrc);
                chk($sformatf("v%0d.dst", n), bus.OUT_dst, vecs[n].eDst);
                chk($sformatf("v%0d.jump", n), 32'(bus.OUT_isJump),
                    32'(vecs[n].eJ));
                chk($sformatf("v%0d.call", n), 32'(bus.OUT_isCall),
                    32'(vecs[n].eC));
                chk($sformatf("v%0d.comp", n), 32'(bus.OUT_compressed),
                    32'(vecs[n].eCmp));
            end
        end

        // Collision on an absent entry, then on a present one
        bus.IN_lookupValid = 1'b1;
        bus.IN_lookupPC = 32'h1004;
        setUpd(32'h1004, 32'h4000, 0, 0, 0, 0);
        cycle();
        bus.IN_btUpdate = '0;
        cycle();
        idle();
        chk("col1.old.hit", 32'(bus.OUT_hit), 32'd0);
        cycle();
        chk("col1.new.hit", 32'(bus.OUT_hit), 32'd1);
        chk("col1.new.dst", bus.OUT_dst, 32'h4000);

        bus.IN_lookupValid = 1'b1;
        bus.IN_lookupPC = 32'h1004;
        setUpd(32'h1004, 32'h5000, 0, 0, 0, 0);
        cycle();
        bus.IN_btUpdate = '0;
        cycle();
        idle();
        chk("col2.old.hit", 32'(bus.OUT_hit), 32'd1);
        chk("col2.old.dst", bus.OUT_dst, 32'h4000);
        cycle();
        chk("col2.new.hit", 32'(bus.OUT_hit), 32'd1);
        chk("col2.new.dst", bus.OUT_dst, 32'h5000);

        bus.IN_lookupValid = 1'b1;
        bus.IN_lookupPC = 32'h80001004;
        cycle();
        idle();
        cycle();
        chk("alias.hit", 32'(bus.OUT_hit), 32'd1);
        chk("alias.src", bus.OUT_src, 32'h1004);
        chk("alias.dst", bus.OUT_dst, 32'h5000);

        lookupHit("pre.7e", 32'h007E, 1'b1, 32'hFFFFFFF0);

        rst = 1'b0;
        cycle();
        chk("mrst.ready", 32'(bus.OUT_ready), 32'd0);
        chk("mrst.hit", 32'(bus.OUT_hit), 32'd0);
        chk("mrst.dst", bus.OUT_dst, 32'd0);
        rst = 1'b1;
        waitClear("mclr");
        lookupHit("post.1004", 32'h1004, 1'b0, 32'h0);
        lookupHit("post.2010", 32'h2010, 1'b0, 32'h0);
        lookupHit("post.7e", 32'h007E, 1'b0, 32'h0);
        lookupHit("post.1084", 32'h1084, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
